multi_bounce_engine: RTL and testbench
======================================

// Module: multi_bounce_engine
// PURPOSE
//  Parametrised bouncing-object engine: moves NUM_OBJ single-pixel objects over a background image.
//  Objects reflect off the screen borders and off pixels whose image colour equals OBS_COLOR.
//  Drives the pixel-plot interface (x, y, plot_color, plot) and reads the background through image_color.
//  Sits between the background image ROM and the frame-buffer writer.
// PARAMETERS
//  NUM_OBJ      4          number of objects; index width IW = max(1, clog2(NUM_OBJ))
//  X_W / Y_W    8 / 7      coordinate widths
//  X_MAX/Y_MAX  159 / 119  last valid column / row
//  COLOR_W      3          colour width
//  OBS_COLOR    3'b100     background colour treated as an obstacle
//  TICK_CYCLES  1000000    idle cycles between sweeps (>=1); TIMER_W = clog2(TICK_CYCLES+1)
//  START_X/Y    10 / 10    object 0 start position
//  STEP_X/Y     20 / 10    start offset per index; object i starts at (START_X+i*STEP_X, START_Y+i*STEP_Y)
// PORTS
//  clk          in   1        clock
//  reset        in   1        asynchronous, active-high reset
//  enable       in   1        when low, the WAIT timer holds; a sweep already in progress completes
//  x            out  X_W      plot/probe column
//  y            out  Y_W      plot/probe row
//  plot_color   out  COLOR_W  colour to write
//  plot         out  1        write strobe, one pixel per cycle
//  image_color  in   COLOR_W  background colour at (x,y); combinational, same cycle
//  frame_done   out  1        1-cycle pulse on the last DRAW of each sweep
// BEHAVIOUR
//  - Per object i: registers xpos, ypos, xdir, ydir (1 = increment); colour = (i mod (2^COLOR_W-1))+1.
//  - Reset state: START; xpos/ypos at start positions; xdir = ydir = 1 for even i, 0 for odd i; timer=0, idx=0.
//    Outputs: x=0, y=0, plot_color=0, plot=0, frame_done=0.
//  - x, y, plot, plot_color and frame_done decode combinationally from registered state/idx/object regs.
//  - States, one cycle each except WAIT:
//    - START: no plot -> INIT.
//    - INIT: plot object idx at its position in its colour; idx++. After idx = NUM_OBJ-1: idx=0 -> WAIT.
//    - WAIT: plot=0. Timer increments when enable=1. At timer = TICK_CYCLES-1 with enable=1: timer=0 -> ERASE.
//    - ERASE: (x,y) = object pos, plot_color = image_color, plot=1 (restores background).
//    - PROBE_X: x = xpos+/-1 per xdir, y = ypos, plot=0.
//      blocked = candidate outside 0..X_MAX, or image_color == OBS_COLOR.
//      If blocked: flip xdir and latch mx=0. Otherwise mx=1.
//    - PROBE_Y: x = xpos, y = ypos+/-1 per ydir, same rule -> flip ydir and latch my.
//    - MOVE: plot=0. xpos += mx ? (xdir ? +1 : -1) : 0; ypos likewise.
//      Use the direction held before this step's flip; a blocked axis does not move.
//    - DRAW: plot new position in object colour.
//      If idx = NUM_OBJ-1: frame_done=1, idx=0 -> WAIT. Otherwise idx++ -> ERASE.
//  - Sweep length 5*NUM_OBJ cycles; sweep period = TICK_CYCLES + 5*NUM_OBJ cycles.
//  - Corner case: both axes blocked -> both directions flip and the object does not move this step.
//  - Borders are checked before image_color is looked at, so no out-of-range address is used for the decision.
//    During a blocked probe, x/y still show the raw wrapped candidate.
//  - Objects are processed independently; overlapping objects are not an obstacle.
//    An ERASE may restore background over another object, which is redrawn on its own DRAW.
//  - Reset asserted mid-sweep: immediate return to the reset state. plot drops asynchronously. Positions restart.
// TESTING
//  1 Reset, NUM_OBJ=4, TICK_CYCLES=4, image all 0:
//    INIT plots (10,10)c1, (30,20)c2, (50,30)c3, (70,40)c4 on 4 consecutive cycles.
//    First ERASE comes 5 cycles after the last INIT plot.
//  2 Free motion: after sweep 1 -> obj0 DRAW at (11,11), obj1 at (29,19); frame_done pulses once per 24 cycles.
//  3 Border: NUM_OBJ=1, START=(159,50), xdir=1 -> PROBE_X blocked, xdir=0, DRAW at (159,51).
//    Next sweep DRAW at (158,52).
//  4 Obstacle: image (11,10)=OBS_COLOR, obj0 at (10,10) moving +x+y ->
//    xdir flips, DRAW at (10,11); ERASE plot_color equals image_color.
//  5 Corner: START=(0,0), dirs 0/0 -> both flip, DRAW at (0,0); next sweep DRAW at (1,1).
//  6 enable=0 in WAIT holds the timer (no ERASE for 100 cycles). Reset during PROBE_Y -> plot=0 at once.
//    INIT repeats from the start positions.

Source files
------------

// File: rtl/multi_bounce_engine_if.sv
// Pixel-plot bus between the bounce engine, the background ROM and the frame buffer.
// master: drives x, y, plot_color, plot, frame_done; samples image_color.
interface multi_bounce_engine_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3
);
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] plot_color;
  logic               plot;
  logic               frame_done;
  logic [COLOR_W-1:0] image_color;

  modport master (
    output x, y, plot_color, plot, frame_done,
    input  image_color
  );

  modport slave (
    input  x, y, plot_color, plot, frame_done,
    output image_color
  );
endinterface

// File: rtl/multi_bounce_engine.sv
// Bouncing-object engine: moves NUM_OBJ pixels over a background, bouncing off
// borders and OBS_COLOR pixels. Ports: clk, reset (async high), enable, bus.
module multi_bounce_engine #(
  parameter int NUM_OBJ     = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int COLOR_W     = 3,
  parameter logic [COLOR_W-1:0] OBS_COLOR = 3'b100,
  parameter int TICK_CYCLES = 1000000,
  parameter int START_X     = 10,
  parameter int START_Y     = 10,
  parameter int STEP_X      = 20,
  parameter int STEP_Y      = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  multi_bounce_engine_if.master bus
);
  localparam int IW      = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int TIMER_W = $clog2(TICK_CYCLES + 1);
  localparam int NSLOT   = 2 ** IW;
  localparam int NCOL    = (2 ** COLOR_W) - 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_OBJ - 1);

  typedef enum logic [2:0] {
    START, INIT, WAIT, ERASE, PROBE_X, PROBE_Y, MOVE, DRAW
  } state_t;

  state_t state, state_d;
  logic [IW-1:0]      idx, idx_d;
  logic [TIMER_W-1:0] timer, timer_d;
  logic               mx, my;

  // Slots past NUM_OBJ-1 are never selected; sizing to 2**IW keeps
  // the idx select in range for any NUM_OBJ.
  logic [X_W-1:0] xpos [NSLOT];
  logic [Y_W-1:0] ypos [NSLOT];
  logic           xdir [NSLOT];
  logic           ydir [NSLOT];

  logic [X_W-1:0]     cur_x, cand_x;
  logic [Y_W-1:0]     cur_y, cand_y;
  logic               cur_xd, cur_yd;
  logic [COLOR_W-1:0] cur_col;
  logic               blk_x, blk_y;

  assign cur_x   = xpos[idx];
  assign cur_y   = ypos[idx];
  assign cur_xd  = xdir[idx];
  assign cur_yd  = ydir[idx];
  assign cur_col = COLOR_W'((32'(idx) % NCOL) + 1);
  assign cand_x  = cur_xd ? cur_x + 1'b1 : cur_x - 1'b1;
  assign cand_y  = cur_yd ? cur_y + 1'b1 : cur_y - 1'b1;

  // Border decided from the current position, so a wrapped candidate
  // address never influences the result.
  assign blk_x = (cur_xd ? (cur_x >= X_W'(X_MAX)) : (cur_x == '0))
               || (bus.image_color == OBS_COLOR);
  assign blk_y = (cur_yd ? (cur_y >= Y_W'(Y_MAX)) : (cur_y == '0))
               || (bus.image_color == OBS_COLOR);

  always_comb begin
    state_d        = state;
    idx_d          = idx;
    timer_d        = timer;
    bus.x          = '0;
    bus.y          = '0;
    bus.plot_color = '0;
    bus.plot       = 1'b0;
    bus.frame_done = 1'b0;
    unique case (state)
      START: state_d = INIT;
      INIT: begin
        bus.x          = cur_x;
        bus.y          = cur_y;
        bus.plot_color = cur_col;
        bus.plot       = 1'b1;
        if (idx == LAST) begin
          idx_d   = '0;
          state_d = WAIT;
        end else begin
          idx_d = idx + 1'b1;
        end
      end
      WAIT: begin
        if (enable) begin
          if (timer == TIMER_W'(TICK_CYCLES - 1)) begin
            timer_d = '0;
            state_d = ERASE;
          end else begin
            timer_d = timer + 1'b1;
          end
        end
      end
      ERASE: begin
        bus.x          = cur_x;
        bus.y          = cur_y;
        bus.plot_color = bus.image_color;
        bus.plot       = 1'b1;
        state_d        = PROBE_X;
      end
      PROBE_X: begin
        bus.x   = cand_x;
        bus.y   = cur_y;
        state_d = PROBE_Y;
      end
      PROBE_Y: begin
        bus.x   = cur_x;
        bus.y   = cand_y;
        state_d = MOVE;
      end
      MOVE: state_d = DRAW;
      DRAW: begin
        bus.x          = cur_x;
        bus.y          = cur_y;
        bus.plot_color = cur_col;
        bus.plot       = 1'b1;
        if (idx == LAST) begin
          bus.frame_done = 1'b1;
          idx_d          = '0;
          state_d        = WAIT;
        end else begin
          idx_d   = idx + 1'b1;
          state_d = ERASE;
        end
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= START;
      idx   <= '0;
      timer <= '0;
      mx    <= 1'b0;
      my    <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        xpos[i] <= X_W'(START_X + i * STEP_X);
        ypos[i] <= Y_W'(START_Y + i * STEP_Y);
        xdir[i] <= (i % 2 == 0);
        ydir[i] <= (i % 2 == 0);
      end
    end else begin
      state <= state_d;
      idx   <= idx_d;
      timer <= timer_d;
      if (state == PROBE_X) begin
        mx <= ~blk_x;
        if (blk_x) xdir[idx] <= ~cur_xd;
      end
      if (state == PROBE_Y) begin
        my <= ~blk_y;
        if (blk_y) ydir[idx] <= ~cur_yd;
      end
      // A blocked axis has mx/my clear, so a flipped direction
      // never moves the object in the same step.
      if (state == MOVE) begin
        if (mx) xpos[idx] <= cur_xd ? cur_x + 1'b1 : cur_x - 1'b1;
        if (my) ypos[idx] <= cur_yd ? cur_y + 1'b1 : cur_y - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_multi_bounce_engine.sv
// Directed bench: four engine instances (free motion, border, obstacle,
// corner) on one clock and reset, checked at hand-computed cycles.
module tb_multi_bounce_engine;
  logic clk = 1'b0;
  logic reset;
  logic en_a;
  logic en_1 = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   fd_cnt;
  int   holds;
  int   k;

  always #5 clk = ~clk;

  multi_bounce_engine_if ia ();
  multi_bounce_engine_if ib ();
  multi_bounce_engine_if ic ();
  multi_bounce_engine_if id ();

  assign ia.image_color = 3'd0;
  assign ib.image_color = 3'd0;
  assign ic.image_color = (ic.x == 8'd11 && ic.y == 7'd10) ? 3'b100 : 3'b010;
  assign id.image_color = 3'd0;

  multi_bounce_engine #(.NUM_OBJ(4), .TICK_CYCLES(4)) ua (
    .clk(clk), .reset(reset), .enable(en_a), .bus(ia.master));
  multi_bounce_engine #(.NUM_OBJ(1), .TICK_CYCLES(4),
    .START_X(159), .START_Y(50)) ub (
    .clk(clk), .reset(reset), .enable(en_1), .bus(ib.master));
  multi_bounce_engine #(.NUM_OBJ(1), .TICK_CYCLES(4)) uc (
    .clk(clk), .reset(reset), .enable(en_1), .bus(ic.master));
  multi_bounce_engine #(.NUM_OBJ(2), .TICK_CYCLES(4),
    .START_X(0), .START_Y(0), .STEP_X(0), .STEP_Y(0)) ud (
    .clk(clk), .reset(reset), .enable(en_1), .bus(id.master));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic p, input logic [7:0] x,
                                     input logic [6:0] y, input logic [2:0] c);
    return {13'd0, p, x, y, c};
  endfunction

  function automatic logic [31:0] pxy(input logic p, input logic [7:0] x,
                                      input logic [6:0] y);
    return {16'd0, p, x, y};
  endfunction

  initial begin
    reset = 1'b1;
    en_a  = 1'b1;
    fd_cnt = 0;
    holds  = 0;
    repeat (2) @(negedge clk);
    check("rst_out", pk(ia.plot, ia.x, ia.y, ia.plot_color), pk(0, 0, 0, 0));
    check("rst_fd", 32'(ia.frame_done), 32'd0);
    reset = 1'b0;

    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      if (ia.frame_done) fd_cnt++;
      case (c)
        1: begin
          check("a_init0", pk(ia.plot, ia.x, ia.y, ia.plot_color), pk(1, 10, 10, 1));
          check("b_init", pk(ib.plot, ib.x, ib.y, ib.plot_color), pk(1, 159, 50, 1));
          check("d_init0", pk(id.plot, id.x, id.y, id.plot_color), pk(1, 0, 0, 1));
        end
        2: begin
          check("a_init1", pk(ia.plot, ia.x, ia.y, ia.plot_color), pk(1, 30, 20, 2));
          check("d_init1", pk(id.plot, id.x, id.y, id.plot_color), pk(1, 0, 0, 2));
        end
        3: check("a_init2", pk(ia.plot, ia.x, ia.y, ia.plot_color), pk(1, 50, 30, 3));
        4: check("a_init3", pk(ia.plot, ia.x, ia.y, ia.plot_color), pk(1, 70, 40, 4));
        5: check("a_wait0", 32'(ia.plot), 32'd0);
        6: begin
          check("b_erase", pk(ib.plot, ib.x, ib.y, ib.plot_color), pk(1, 159, 50, 0));
          check("c_erase", pk(ic.plot, ic.x, ic.y, ic.plot_color), pk(1, 10, 10, 2));
        end
        7: begin
          check("b_probex", pxy(ib.plot, ib.x, ib.y), pxy(0, 160, 50));
          check("c_probex", pxy(ic.plot, ic.x, ic.y), pxy(0, 11, 10));
        end
        8: begin
          check("a_wait3", 32'(ia.plot), 32'd0);
          check("c_probey", pxy(ic.plot, ic.x, ic.y), pxy(0, 10, 11));
        end
        9: check("a_erase0", pk(ia.plot, ia.x, ia.y, ia.plot_color), pk(1, 10, 10, 0));
        10: begin
          check("a_probex", pxy(ia.plot, ia.x, ia.y), pxy(0, 11, 10));
          check("b_draw1", pk(ib.plot, ib.x, ib.y, ib.plot_color), pk(1, 159, 51, 1));
          check("b_fd", 32'(ib.frame_done), 32'd1);
          check("c_draw1", pk(ic.plot, ic.x, ic.y, ic.plot_color), pk(1, 10, 11, 1));
        end
        11: check("d_draw0", pk(id.plot, id.x, id.y, id.plot_color), pk(1, 1, 1, 1));
        13: begin
          check("a_draw0", pk(ia.plot, ia.x, ia.y, ia.plot_color), pk(1, 11, 11, 1));
          check("d_probex", pxy(id.plot, id.x, id.y), pxy(0, 255, 0));
        end
        14: check("d_probey", pxy(id.plot, id.x, id.y), pxy(0, 0, 127));
        15: check("c_erase2", pk(ic.plot, ic.x, ic.y, ic.plot_color), pk(1, 10, 11, 2));
        16: begin
          check("d_draw1", pk(id.plot, id.x, id.y, id.plot_color), pk(1, 0, 0, 2));
          check("d_fd", 32'(id.frame_done), 32'd1);
        end
        18: check("a_draw1", pk(ia.plot, ia.x, ia.y, ia.plot_color), pk(1, 29, 19, 2));
        19: begin
          check("b_draw2", pk(ib.plot, ib.x, ib.y, ib.plot_color), pk(1, 158, 52, 1));
          check("c_draw2", pk(ic.plot, ic.x, ic.y, ic.plot_color), pk(1, 9, 12, 1));
        end
        25: check("d_draw0b", pk(id.plot, id.x, id.y, id.plot_color), pk(1, 2, 2, 1));
        27: check("a_fd_lo", 32'(ia.frame_done), 32'd0);
        28: begin
          check("a_draw3", pk(ia.plot, ia.x, ia.y, ia.plot_color), pk(1, 69, 39, 4));
          check("a_fd1", 32'(ia.frame_done), 32'd1);
        end
        30: check("d_draw1b", pk(id.plot, id.x, id.y, id.plot_color), pk(1, 1, 1, 2));
        52: check("a_fd2", 32'(ia.frame_done), 32'd1);
        default: ;
      endcase
    end
    check("a_fd_count", 32'(fd_cnt), 32'd2);

    @(negedge clk);
    en_a = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ia.plot) holds++;
    end
    check("a_hold", 32'(holds), 32'd0);
    en_a = 1'b1;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ia.plot) begin
        k = i;
        break;
      end
    end
    check("a_resume_lat", 32'(k), 32'd4);
    check("a_erase_b", pk(ia.plot, ia.x, ia.y, ia.plot_color), pk(1, 12, 12, 0));
    repeat (2) @(negedge clk);
    check("a_probey_b", pxy(ia.plot, ia.x, ia.y), pxy(0, 12, 13));
    reset = 1'b1;
    #1;
    check("a_async_rst", pk(ia.plot, ia.x, ia.y, ia.plot_color), pk(0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("a_reinit0", pk(ia.plot, ia.x, ia.y, ia.plot_color), pk(1, 10, 10, 1));
    @(negedge clk);
    check("a_reinit1", pk(ia.plot, ia.x, ia.y, ia.plot_color), pk(1, 30, 20, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
